// File: rtl/tan_series_pkg.sv
// tan_series_pkg: shared coefficients, divider width and FSM states for the tangent series evaluator.
package tan_series_pkg;
   localparam int DIV_W = 9;
   localparam int COEF_N [0:3] = '{1, 1, 2, 17};
   localparam int COEF_D [0:3] = '{1, 3, 15, 315};
   typedef enum logic [2:0] {S_IDLE, S_INIT, S_POW, S_DIV, S_SCALE, S_ACC, S_DONE} state_t;
endpackage

// File: rtl/seq_restoring_div.sv
// seq_restoring_div: restoring divider producing one quotient bit per step, MSB first.
module seq_restoring_div #(
   parameter int WIDTH = 6,
   parameter int DW    = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [DW-1:0]    divisor,
   output logic [WIDTH-1:0] quotient
);
   logic [DW-1:0]    rem;
   logic [WIDTH-1:0] a;
   logic [DW:0]      trial, diff;
   logic             ge;
   assign trial    = {rem, a[WIDTH-1]};
   assign diff     = trial - {1'b0, divisor};
   assign ge       = trial >= {1'b0, divisor};
   assign quotient = a;
   // dividend bits shift out of the top of a while quotient bits shift in at the bottom
   always_ff @(posedge clk) begin
      if (rst) begin
         rem <= '0;
         a   <= '0;
      end else if (load) begin
         rem <= '0;
         a   <= dividend;
      end else if (step) begin
         rem <= ge ? diff[DW-1:0] : trial[DW-1:0];
         a   <= {a[WIDTH-2:0], ge};
      end
   end
endmodule

// File: rtl/tan_series_seq.sv
// tan_series_seq: multi-cycle truncated tangent series x + x^3/3 + 2x^5/15 + 17x^7/315 with sticky overflow.
module tan_series_seq
   import tan_series_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int TERMS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);
   localparam int DW = WIDTH > DIV_W ? WIDTH : DIV_W;
   localparam int MW = WIDTH > 5 ? WIDTH : 5;
   localparam int CW = $clog2(WIDTH);
   state_t           state, state_n;
   logic [WIDTH-1:0] x_r, x2, p, acc, t, quo, addend;
   logic [1:0]       k;
   logic [CW-1:0]    cnt;
   logic             pow_ovf, zero_t, ovf_m, last_k;
   logic [MW-1:0]    ma, mb;
   logic [2*MW-1:0]  prod;
   logic [WIDTH:0]   sum;
   // one multiplier shared by x*x (INIT), p*x2 (POW) and q*N_k (SCALE)
   assign ma     = state == S_INIT ? MW'(x_r) : state == S_POW ? MW'(p)  : MW'(quo);
   assign mb     = state == S_INIT ? MW'(x_r) : state == S_POW ? MW'(x2) : MW'(COEF_N[k]);
   assign prod   = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
   assign ovf_m  = |prod[2*MW-1:WIDTH];
   assign addend = zero_t ? '0 : t;
   assign sum    = {1'b0, acc} + {1'b0, addend};
   assign last_k = k == 2'(TERMS - 1);
   assign busy   = state != S_IDLE;
   assign done   = state == S_DONE;
   seq_restoring_div #(.WIDTH(WIDTH), .DW(DW)) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (state == S_POW),
      .step     (state == S_DIV),
      .dividend (prod[WIDTH-1:0]),
      .divisor  (DW'(COEF_D[k])),
      .quotient (quo)
   );
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = start ? S_INIT : S_IDLE;
         S_INIT:  state_n = TERMS == 1 ? S_DONE : S_POW;
         S_POW:   state_n = S_DIV;
         S_DIV:   state_n = cnt == CW'(WIDTH - 1) ? S_SCALE : S_DIV;
         S_SCALE: state_n = S_ACC;
         S_ACC:   state_n = last_k ? S_DONE : S_POW;
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r      <= '0;
         x2       <= '0;
         p        <= '0;
         acc      <= '0;
         t        <= '0;
         k        <= '0;
         cnt      <= '0;
         pow_ovf  <= 1'b0;
         zero_t   <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               x_r      <= x_in;
               overflow <= 1'b0;
            end
            S_INIT: begin
               acc      <= x_r;
               p        <= x_r;
               x2       <= prod[WIDTH-1:0];
               pow_ovf  <= ovf_m;
               overflow <= ovf_m;
               k        <= 2'd1;
               if (TERMS == 1) result <= x_r;
            end
            S_POW: begin
               p   <= prod[WIDTH-1:0];
               cnt <= '0;
               if (ovf_m) begin
                  pow_ovf  <= 1'b1;
                  overflow <= 1'b1;
               end
            end
            S_DIV: cnt <= cnt + 1'b1;
            S_SCALE: begin
               t      <= prod[WIDTH-1:0];
               zero_t <= pow_ovf | ovf_m;
               if (ovf_m) overflow <= 1'b1;
            end
            S_ACC: begin
               acc <= sum[WIDTH-1:0];
               if (sum[WIDTH]) overflow <= 1'b1;
               if (last_k) result <= sum[WIDTH-1:0];
               else k <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tan_series_seq.sv
// tb_tan_series_seq: directed and random checks of tan_series_seq against an arithmetic series model.
module tb_tan_series_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [5:0] x_a = '0, res_a;
   logic [7:0] x_b = '0, res_b;
   logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
   int         checks = 0, failures = 0;
   int         cn [4] = '{1, 1, 2, 17};
   int         cd [4] = '{1, 3, 15, 315};
   always #5 clk = ~clk;
   tan_series_seq #(.WIDTH(6), .TERMS(3)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .x_in(x_a),
      .busy(busy_a), .done(done_a), .result(res_a), .overflow(ovf_a)
   );
   tan_series_seq #(.WIDTH(8), .TERMS(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .x_in(x_b),
      .busy(busy_b), .done(done_b), .result(res_b), .overflow(ovf_b)
   );
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic logic [15:0] get_res(input int inst);
      return inst != 0 ? 16'(res_b) : 16'(res_a);
   endfunction
   function automatic logic get_done(input int inst);
      return inst != 0 ? done_b : done_a;
   endfunction
   function automatic logic get_busy(input int inst);
      return inst != 0 ? busy_b : busy_a;
   endfunction
   function automatic logic get_ovf(input int inst);
      return inst != 0 ? ovf_b : ovf_a;
   endfunction
   task automatic model(input int w, input int nt, input longint x, output longint r, output logic o);
      longint mask = (longint'(1) << w) - 1;
      longint acc = x, p = x, x2 = x * x, q, tm;
      bit bad = x2 > mask;
      o = bad;
      for (int k = 1; k < nt; k++) begin
         tm = 0;
         if (!bad) begin
            p = p * x2;
            if (p > mask) begin
               bad = 1;
               o = 1'b1;
            end
         end
         if (!bad) begin
            q = p / cd[k];
            tm = q * cn[k];
            if (tm > mask) begin
               o = 1'b1;
               tm = 0;
            end
         end
         acc = acc + tm;
         if (acc > mask) begin
            o = 1'b1;
            acc = acc & mask;
         end
      end
      r = acc;
   endtask
   // called at a falling edge; that cycle is the accepting cycle 0
   task automatic eval(input int inst, input int x, input string tag);
      int     w = inst != 0 ? 8 : 6;
      int     nt = inst != 0 ? 4 : 3;
      int     lat = 2 + (nt - 1) * (w + 3);
      int     cyc = 0;
      longint er;
      logic   eo;
      model(w, nt, longint'(x), er, eo);
      if (inst != 0) begin
         x_b = 8'(x);
         start_b = 1'b1;
      end else begin
         x_a = 6'(x);
         start_a = 1'b1;
      end
      do begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         cyc++;
         if (cyc == 1) begin
            check({tag, " busy_after_start"}, 64'(get_busy(inst)), 64'd1);
            x_a = 6'($urandom);
            x_b = 8'($urandom);
         end
      end while (!get_done(inst) && cyc < 200);
      check({tag, " latency"}, 64'(cyc), 64'(lat));
      check({tag, " result"}, 64'(get_res(inst)), 64'(er));
      check({tag, " overflow"}, 64'(get_ovf(inst)), 64'(eo));
      check({tag, " busy_with_done"}, 64'(get_busy(inst)), 64'd1);
      @(negedge clk);
      check({tag, " done_one_cycle"}, 64'(get_done(inst)), 64'd0);
      check({tag, " idle_after"}, 64'(get_busy(inst)), 64'd0);
      check({tag, " result_held"}, 64'(get_res(inst)), 64'(er));
   endtask
   initial begin
      int cyc, ndone;
      repeat (2) @(negedge clk);
      check("reset busy_a", 64'(busy_a), 64'd0);
      check("reset done_a", 64'(done_a), 64'd0);
      check("reset result_a", 64'(res_a), 64'd0);
      check("reset ovf_a", 64'(ovf_a), 64'd0);
      check("reset busy_b", 64'(busy_b), 64'd0);
      check("reset result_b", 64'(res_b), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      eval(0, 2, "a x=2");
      eval(0, 3, "a x=3");
      eval(0, 8, "a x=8");
      eval(0, 0, "a x=0");
      eval(0, 63, "a x=63");
      eval(1, 3, "b x=3");
      eval(1, 2, "b x=2");
      eval(1, 255, "b x=255");
      for (int i = 0; i < 12; i++) begin
         eval(0, int'($urandom_range(0, 63)), "a random");
         eval(1, int'($urandom_range(0, 255)), "b random");
      end
      // start held high: only starts seen in IDLE are accepted
      x_a = 6'd1;
      start_a = 1'b1;
      cyc = 0;
      ndone = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         cyc++;
         if (done_a) begin
            ndone++;
            check("pulse result", 64'(res_a), 64'd1);
            check("pulse overflow", 64'(ovf_a), 64'd0);
            check("pulse done_cycle", 64'(cyc), ndone == 1 ? 64'd20 : 64'd41);
         end
      end
      start_a = 1'b0;
      check("pulse done_count", 64'(ndone), 64'd2);
      cyc = 0;
      while (busy_a && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      check("pulse drained", 64'(busy_a), 64'd0);
      // reset in the middle of an evaluation
      eval(0, 3, "a pre-reset");
      x_a = 6'd2;
      start_a = 1'b1;
      cyc = 0;
      ndone = 0;
      while (cyc < 7) begin
         @(negedge clk);
         start_a = 1'b0;
         cyc++;
         if (done_a) ndone++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort no_done", 64'(ndone), 64'd0);
      check("abort busy", 64'(busy_a), 64'd0);
      check("abort done", 64'(done_a), 64'd0);
      check("abort result", 64'(res_a), 64'd0);
      check("abort overflow", 64'(ovf_a), 64'd0);
      rst = 1'b0;
      eval(0, 0, "a after-reset x=0");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tan_series_seq.md
Name: tan_series_seq

Overview:
- Multi-cycle, parametrised evaluator of the truncated tangent series x + x^3/3 + 2x^5/15 + 17x^7/315 on unsigned integers.
- Successor to the combinational six-bit tangent unit in the calculator datapath.
- Adds configurable width and term count, one shared multiplier and one iterative divider, a start/done handshake, and a sticky overflow flag.
- Sits between operand register and result mux; one evaluation in flight.

Parameters:
WIDTH, 6, operand/result width in bits (4..16)
TERMS, 3, number of series terms evaluated (1..4); coefficient N_k/D_k for k=0..3 = 1/1, 1/3, 2/15, 17/315

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  request; sampled only in IDLE
x_in  in  WIDTH  operand, latched on accepted start
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse, result/overflow valid
result  out  WIDTH  series sum modulo 2^WIDTH, held until next accepted start
overflow  out  1  sticky per evaluation, held with result

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, overflow=0, internal regs 0. Reset mid-evaluation aborts it and no done is produced.
- Integer semantics per term k>=1: p_k = x^(2k+1) truncated check; q_k = floor(p_k / D_k); t_k = q_k * N_k; acc = acc + t_k.
- Overflow rules (all set overflow):
  - Any product exceeding WIDTH bits: x*x, p*x2, q*N.
  - Accumulator carry-out.
- Power overflow is sticky for the evaluation: that term and all later terms contribute 0.
- Scale overflow zeroes only that term.
- Accumulator overflow wraps and does not zero.
- States:
  - IDLE: start=1 -> INIT; latch x, clear overflow.
  - INIT (1 cycle): acc=x, p=x, x2=x*x (flag if overflow); TERMS==1 -> DONE else POW, k=1.
  - POW (1 cycle): p=p*x2.
  - DIV (WIDTH cycles): restoring division p/D_k, one quotient bit per cycle MSB first. Divisor register is max(WIDTH,9) bits, so D_k > p yields 0 with no overflow.
  - SCALE (1 cycle): t=q*N_k.
  - ACC (1 cycle): acc=acc+t (or +0 if zeroed); k==TERMS-1 -> DONE else k++, POW.
  - DONE (1 cycle): result=acc, done=1 -> IDLE.
- Latency: start accepted in cycle 0 -> done in cycle 1+(TERMS-1)*(WIDTH+3)+1. Default: cycle 20. Fixed, data-independent.
- start while not IDLE is ignored. start in the DONE cycle is ignored; earliest re-accept is the cycle after done.
- busy and done are asserted together in the DONE cycle.
- x=0: all terms 0, result 0, no overflow, full latency.

Decomposition:
- Shared package tan_series_pkg:
  - Coefficient arrays COEF_N[0:3]={1,1,2,17} and COEF_D[0:3]={1,3,15,315}.
  - State encoding localparams.
  - DIV_W = 9 constant.
- Sub-module seq_restoring_div: WIDTH-bit dividend, DIV_W divisor, load/step/quotient, WIDTH-cycle iteration.
- Multiplier stays inline as a single shared combinational product with overflow compare.

Test Plan:
- WIDTH=6, TERMS=3, x=2 -> 8/3=2, 32/15*2=4; done at cycle 20, result=8, overflow=0.
- WIDTH=6, TERMS=3, x=3 -> 27/3=9, x^5=243 overflows; result=12, overflow=1.
- WIDTH=6, TERMS=3, x=8 -> x*x=64 overflows, terms 1..2 zeroed; result=8, overflow=1.
- WIDTH=8, TERMS=4, x=3 -> 9 + (243/15=16)*2=32, x^7 overflows; result=44, overflow=1, done at cycle 1+3*11+1=35.
- WIDTH=6, TERMS=3, x=1 then start pulses every cycle -> result=1, overflow=0; starts during busy/DONE ignored; exactly one done per accepted start.
- Assert rst at cycle 7 of an x=2 evaluation -> no done; all outputs 0 next cycle; new start with x=0 -> result=0, overflow=0 at cycle 20.
